// File: rtl/cla_adder_64bit_if.sv
// Operand/result bundle for the 64-bit carry-lookahead adder.
// The master drives the operands; the slave returns the sums.
interface cla_adder_64bit_if;
    logic [63:0] A;
    logic [63:0] B;
    logic        c_in;
    logic [63:0] Sum;
    logic        c_out;
    logic [63:0] Sum_q;
    logic        c_out_q;

    modport master (
        output A, B, c_in,
        input  Sum, c_out, Sum_q, c_out_q
    );

    modport slave (
        input  A, B, c_in,
        output Sum, c_out, Sum_q, c_out_q
    );
endinterface

// File: rtl/cla_adder_64bit.sv
// Hierarchical 64-bit carry-lookahead adder (4-bit blocks, 16-bit groups).
// A combinational sum is exposed together with a registered copy.
module cla_lcu (
    input  logic [3:0] g,
    input  logic [3:0] p,
    input  logic       ci,
    output logic [3:1] c,
    output logic       gg,
    output logic       pg
);
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);
    assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);
    assign pg   = &p;
endmodule

module cla4_block (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] sum,
    output logic       gg,
    output logic       pg
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:1] c;

    assign g = a & b;
    assign p = a ^ b;

    cla_lcu u_lcu (
        .g  (g),
        .p  (p),
        .ci (ci),
        .c  (c),
        .gg (gg),
        .pg (pg)
    );

    assign sum = p ^ {c[3:1], ci};
endmodule

module cla16_group (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    output logic [15:0] sum,
    output logic        gg,
    output logic        pg
);
    logic [3:0] g4;
    logic [3:0] p4;
    logic [3:1] c4;
    logic [3:0] cin4;

    // Block carries come only from the lookahead unit, never rippled.
    assign cin4 = {c4[3:1], ci};

    for (genvar i = 0; i < 4; i++) begin : g_blk
        cla4_block u_blk (
            .a   (a[4*i +: 4]),
            .b   (b[4*i +: 4]),
            .ci  (cin4[i]),
            .sum (sum[4*i +: 4]),
            .gg  (g4[i]),
            .pg  (p4[i])
        );
    end

    cla_lcu u_lcu (
        .g  (g4),
        .p  (p4),
        .ci (ci),
        .c  (c4),
        .gg (gg),
        .pg (pg)
    );
endmodule

module cla_adder_64bit (
    input  logic                     clk,
    input  logic                     rst,
    cla_adder_64bit_if.slave         bus
);
    logic [3:0]  g16;
    logic [3:0]  p16;
    logic [3:1]  c16;
    logic [3:0]  cin16;
    logic        g64;
    logic        p64;
    logic [63:0] sum;
    logic        cout;

    assign cin16 = {c16[3:1], bus.c_in};

    for (genvar i = 0; i < 4; i++) begin : g_grp
        cla16_group u_grp (
            .a   (bus.A[16*i +: 16]),
            .b   (bus.B[16*i +: 16]),
            .ci  (cin16[i]),
            .sum (sum[16*i +: 16]),
            .gg  (g16[i]),
            .pg  (p16[i])
        );
    end

    cla_lcu u_lcu (
        .g  (g16),
        .p  (p16),
        .ci (bus.c_in),
        .c  (c16),
        .gg (g64),
        .pg (p64)
    );

    assign cout      = g64 | (p64 & bus.c_in);
    assign bus.Sum   = sum;
    assign bus.c_out = cout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.Sum_q   <= '0;
            bus.c_out_q <= 1'b0;
        end else begin
            bus.Sum_q   <= sum;
            bus.c_out_q <= cout;
        end
    end
endmodule

// File: tb/tb_cla_adder_64bit.sv
// Self-checking bench for cla_adder_64bit: directed boundaries,
// register/reset behaviour and random vectors against a 65-bit model.
module tb_cla_adder_64bit;
    logic clk;
    logic rst;
    int   checks;
    int   passed;

    cla_adder_64bit_if bus ();

    cla_adder_64bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [64:0] ref_add(
        input logic [63:0] a,
        input logic [63:0] b,
        input logic        ci
    );
        return {1'b0, a} + {1'b0, b} + {64'd0, ci};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.A = '0;
        bus.B = '0;
        bus.c_in = 1'b0;
        #2;
        checks++;
        if ({bus.c_out_q, bus.Sum_q} !== 65'd0)
            $display("FAIL reset_q: got %h want 0",
                     {bus.c_out_q, bus.Sum_q});
        else passed++;
    endtask

    task automatic test_directed();
        logic [63:0] ta [11];
        logic [63:0] tb [11];
        logic        tc [11];
        logic [64:0] te [11];
        logic [64:0] got;
        ta[0]  = 64'd0;                  tb[0]  = 64'd0; tc[0]  = 0;
        te[0]  = 65'd0;
        ta[1]  = 64'd0;                  tb[1]  = 64'd1; tc[1]  = 0;
        te[1]  = 65'd1;
        ta[2]  = 64'd1;                  tb[2]  = 64'd0; tc[2]  = 0;
        te[2]  = 65'd1;
        ta[3]  = 64'h7FFF_FFFF_FFFF_FFFF; tb[3]  = 64'd1; tc[3]  = 0;
        te[3]  = {1'b0, 64'h8000_0000_0000_0000};
        ta[4]  = 64'h7FFF_FFFF_FFFF_FFFF; tb[4]  = ta[4]; tc[4]  = 0;
        te[4]  = {1'b0, 64'hFFFF_FFFF_FFFF_FFFE};
        ta[5]  = 64'h7FFF_FFFF_FFFF_FFFE; tb[5]  = ta[5]; tc[5]  = 0;
        te[5]  = {1'b0, 64'hFFFF_FFFF_FFFF_FFFC};
        ta[6]  = 64'hFFFF_FFFF_FFFF_FFFF; tb[6]  = 64'd1; tc[6]  = 0;
        te[6]  = {1'b1, 64'd0};
        ta[7]  = 64'hFFFF_FFFF_FFFF_FFFF; tb[7]  = 64'd0; tc[7]  = 1;
        te[7]  = {1'b1, 64'd0};
        ta[8]  = 64'hFFFF_FFFF_FFFF_FFFF; tb[8]  = ta[8]; tc[8]  = 1;
        te[8]  = {1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        ta[9]  = 64'h0000_0000_0000_FFFF; tb[9]  = 64'd1; tc[9]  = 0;
        te[9]  = {1'b0, 64'h0000_0000_0001_0000};
        ta[10] = 64'h0000_FFFF_FFFF_FFFF; tb[10] = 64'd0; tc[10] = 1;
        te[10] = {1'b0, 64'h0001_0000_0000_0000};
        for (int i = 0; i < 11; i++) begin
            bus.A = ta[i];
            bus.B = tb[i];
            bus.c_in = tc[i];
            #1;
            got = {bus.c_out, bus.Sum};
            checks++;
            if (got !== te[i])
                $display("FAIL directed_%0d: got %h want %h",
                         i, got, te[i]);
            else passed++;
        end
    endtask

    task automatic test_register();
        @(negedge clk);
        rst = 1'b0;
        bus.A = 64'd5;
        bus.B = 64'd7;
        bus.c_in = 1'b0;
        #1;
        checks++;
        if ({bus.c_out, bus.Sum} !== 65'd12)
            $display("FAIL comb_5p7: got %0d want 12", bus.Sum);
        else passed++;
        checks++;
        if ({bus.c_out_q, bus.Sum_q} !== 65'd0)
            $display("FAIL q_before_edge: got %0d want 0", bus.Sum_q);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.c_out_q, bus.Sum_q} !== 65'd12)
            $display("FAIL q_after_edge: got %0d want 12", bus.Sum_q);
        else passed++;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.c_out_q, bus.Sum_q} !== 65'd0)
            $display("FAIL q_async_clr: got %0d want 0", bus.Sum_q);
        else passed++;
        checks++;
        if ({bus.c_out, bus.Sum} !== 65'd12)
            $display("FAIL comb_in_rst: got %0d want 12", bus.Sum);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.c_out_q, bus.Sum_q} !== 65'd0)
            $display("FAIL q_held_rst: got %0d want 0", bus.Sum_q);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [63:0] a;
        logic [63:0] b;
        logic        ci;
        logic [64:0] exp;
        int          bad_c;
        int          bad_q;
        bad_c = 0;
        bad_q = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) b = ~a;
            ci = 1'($urandom);
            bus.A = a;
            bus.B = b;
            bus.c_in = ci;
            exp = ref_add(a, b, ci);
            #1;
            checks++;
            if ({bus.c_out, bus.Sum} !== exp) begin
                if (bad_c < 5)
                    $display("FAIL rand_comb_%0d: got %h want %h",
                             i, {bus.c_out, bus.Sum}, exp);
                bad_c++;
            end else passed++;
            @(posedge clk);
            #1;
            checks++;
            if ({bus.c_out_q, bus.Sum_q} !== exp) begin
                if (bad_q < 5)
                    $display("FAIL rand_q_%0d: got %h want %h",
                             i, {bus.c_out_q, bus.Sum_q}, exp);
                bad_q++;
            end else passed++;
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_directed();
        test_register();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/cla_adder_64bit.md
Name: cla_adder_64bit

Overview:
- 64-bit carry-lookahead adder used by the datapath ALU for add/subtract and address arithmetic.
- Computes A + B + c_in combinationally, with a carry-out.
- Also provides a registered copy of the result (one clock, async active-high reset) for pipelined consumers.
- Built hierarchically: 4-bit CLA blocks, 16-bit lookahead groups, 64-bit top-level lookahead. No ripple carry across blocks.

Parameters:
- none (width fixed at 64)

Ports:
- clk  input  1  clock; rising-edge registers only
- rst  input  1  asynchronous active-high reset of the registered outputs
- A  input  64  addend A, unsigned
- B  input  64  addend B, unsigned
- c_in  input  1  carry into bit 0
- Sum  output  64  combinational (A + B + c_in)[63:0]
- c_out  output  1  combinational (A + B + c_in)[64]
- Sum_q  output  64  Sum registered on rising clk
- c_out_q  output  1  c_out registered on rising clk

Behaviour:
- Arithmetic:
  - {c_out, Sum} = A + B + c_in, exact 65-bit unsigned result, for all input values.
  - No overflow flag; signed overflow is derived by the consumer.
- Combinational path (Sum, c_out):
  - Zero latency; no dependence on clk or rst.
  - Valid after propagation delay whenever inputs change, including during reset.
- Bit level: g_i = A_i & B_i, p_i = A_i ^ B_i, sum_i = p_i ^ c_i.
- 4-bit block:
  - Lookahead carries c1..c3 from g, p and block carry-in.
  - Block outputs: group generate G = g3 | p3g2 | p3p2g1 | p3p2p1g0; group propagate P = p3p2p1p0.
- 16-bit group:
  - Four 4-bit blocks with a lookahead unit using the same equations on block G/P.
  - Outputs group G16/P16.
- 64-bit top:
  - Four 16-bit groups with a lookahead unit producing carries into bits 16, 32, 48 and c_out.
  - c_out = G64 | (P64 & c_in).
- Registered path (Sum_q, c_out_q):
  - Captures Sum and c_out on every rising clk edge; latency 1 cycle; no enable.
  - rst = 1 forces Sum_q = 0 and c_out_q = 0 immediately, independent of clk, and holds them while asserted.
  - Reset asserted mid-operation discards the value in flight.
  - First capture after deassertion is at the next rising edge.
- Boundaries:
  - All-ones + 1 wraps Sum to 0 with c_out = 1.
  - Carry must propagate across every 4-bit and 16-bit boundary through the lookahead logic.
  - c_in = 1 with A = B = all-ones gives Sum = all-ones, c_out = 1.
- No latches; no X on outputs for known inputs.

Test Plan:
- Zero and unit cases, c_in = 0: A=0,B=0 -> Sum=0,c_out=0; A=0,B=1 -> 1,0; A=1,B=0 -> 1,0.
- Bit-63 boundary:
  - A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> Sum=0x8000_0000_0000_0000, c_out=0.
  - A=B=0x7FFF_FFFF_FFFF_FFFF -> Sum=0xFFFF_FFFF_FFFF_FFFE, c_out=0.
  - A=B=0x7FFF_FFFF_FFFF_FFFE -> Sum=0xFFFF_FFFF_FFFF_FFFC, c_out=0.
- Full carry chain and carry-in:
  - A=0xFFFF_FFFF_FFFF_FFFF, B=1, c_in=0 -> Sum=0, c_out=1.
  - A=0xFFFF_FFFF_FFFF_FFFF, B=0, c_in=1 -> Sum=0, c_out=1.
  - A=B=all-ones, c_in=1 -> Sum=all-ones, c_out=1.
  - A=0x0000_0000_0000_FFFF, B=1 -> Sum=0x0000_0000_0001_0000 (16-bit group boundary).
- Register/reset:
  - rst=1 -> Sum_q=0, c_out_q=0 without a clock edge.
  - Release rst, apply A=5,B=7 -> Sum=12 immediately; Sum_q=12 after the next rising clk.
  - Assert rst between edges -> Sum_q clears at once while Sum stays 12.
- Random: 1000+ random 64-bit A, B and random c_in -> {c_out,Sum} equals the 65-bit reference sum every vector; Sum_q matches the prior cycle's value.
